cache_arbiter: RTL and testbench
================================

# cache_arbiter

Shares the single 256-bit physical-memory port between the instruction cache and the data cache of the pipelined RV32I core. It sits between the two `cache` instances' pmem-side interfaces and main memory. It grants one line transaction at a time: a read for the I-cache, or a read or write-back for the D-cache. When both caches are waiting, grants alternate round-robin. Address, write data and command are registered at grant, so memory sees a stable request for the whole transaction.

## Interface
Parameters: none (widths fixed: 32-bit address, 256-bit line).
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_pmem_read  in  1  I-cache line-read request; held until i_pmem_resp
- i_pmem_address  in  32  I-cache line address (bits [4:0] zero)
- i_pmem_rdata  out  256  line data to I-cache; valid only when i_pmem_resp=1
- i_pmem_resp  out  1  I-cache transaction complete
- d_pmem_read  in  1  D-cache line-read request
- d_pmem_write  in  1  D-cache line write-back request
- d_pmem_address  in  32  D-cache line address
- d_pmem_wdata  in  256  D-cache write-back line
- d_pmem_rdata  out  256  line data to D-cache; valid only when d_pmem_resp=1
- d_pmem_resp  out  1  D-cache transaction complete
- pmem_read  out  1  memory read command
- pmem_write  out  1  memory write command
- pmem_address  out  32  memory address
- pmem_wdata  out  256  memory write data
- pmem_rdata  in  256  memory read data
- pmem_resp  in  1  memory transaction complete

## Operation
- FSM states: IDLE, SERVE_I, SERVE_D. Register last_grant (I/D).
- IDLE:
  - eligible_i = i_pmem_read & ~block_i.
  - eligible_d = (d_pmem_read | d_pmem_write) & ~block_d.
  - Only one eligible: grant it.
  - Both eligible: grant the requester opposite to last_grant.
  - On grant:
    - Latch address into addr_q.
    - Latch d_pmem_wdata into wdata_q (D only).
    - Latch cmd_q = write if d_pmem_write else read. d_pmem_read and d_pmem_write both high is illegal; it is treated as write.
    - Update last_grant and go to the matching SERVE state.
- SERVE_x:
  - pmem_read/pmem_write driven from cmd_q.
  - pmem_address = addr_q; pmem_wdata = wdata_q.
  - Requester inputs are ignored after the latch; changes mid-transaction have no effect.
  - On pmem_resp=1: assert x_pmem_resp combinationally in the same cycle, go to IDLE, and set block_x for one cycle.
- Blackout rule:
  - block_x is high only in the IDLE cycle right after x's resp; it clears after that cycle.
  - Purpose: a requester whose request is still high in that cycle is not re-granted. The other requester may be granted in that cycle.
- Read data:
  - i_pmem_rdata = d_pmem_rdata = pmem_rdata, passed through unregistered.
  - Resp gating: i_pmem_resp = (state==SERVE_I) & pmem_resp; d_pmem_resp = (state==SERVE_D) & pmem_resp.
- pmem_resp in IDLE is ignored; no response is forwarded.
- Reset values:
  - state=IDLE, last_grant=I (first conflict goes to D), block_i=block_d=0.
  - addr_q=0, wdata_q=0, cmd_q=read.
  - Outputs pmem_read=pmem_write=0, i_pmem_resp=d_pmem_resp=0.
- Reset mid-transaction:
  - Commands drop to 0 the cycle after the rst edge. The in-flight transaction is abandoned; no resp is forwarded.
  - A late pmem_resp after reset is ignored.

## Timing
- Requests are sampled at edge N while in IDLE. pmem_read or pmem_write is high from cycle N+1; this is one cycle of arbitration latency.
- pmem_resp in cycle M gives x_pmem_resp in cycle M (zero latency). pmem_read/pmem_write are low from M+1.
- Minimum gap: one IDLE cycle between consecutive transactions.
  - Other requester pending: next command starts at M+2.
  - Same requester re-requesting: earliest command at M+3, because of the blackout.
- pmem_read and pmem_write are never high simultaneously. Neither is high in IDLE.
- At most one of i_pmem_resp/d_pmem_resp is high in any cycle.

## Test plan
- Lone I read:
  - Stimulus: i_pmem_read=1, addr 0x0000_0040; memory responds after 5 cycles with 256'hA5..A5.
  - Required: pmem_read high for 5 cycles, pmem_address=0x40, i_pmem_resp pulses one cycle with i_pmem_rdata=A5..A5, d_pmem_resp stays 0.
- Simultaneous requests after reset:
  - Stimulus: I read 0x100 and D write 0x200 (wdata 256'h1234) asserted in the same cycle.
  - Required: D is served first (pmem_write=1, address 0x200, wdata 0x1234). One IDLE cycle later the I read of 0x100 is issued.
- Sustained contention:
  - Stimulus: both requesters re-request immediately after each resp, for 6 transactions.
  - Required: grants alternate D,I,D,I,D,I and no requester is served twice in a row.
- Blackout:
  - Stimulus: I alone holds i_pmem_read for one extra cycle after its resp.
  - Required: no second pmem_read is issued for that same request; the next I grant starts no earlier than M+3.
- Mid-transaction change:
  - Stimulus: during SERVE_D, change d_pmem_address to 0xFFFF_FFE0.
  - Required: pmem_address stays at the latched value until pmem_resp.
- Reset mid-transaction:
  - Stimulus: assert rst during SERVE_I; memory asserts pmem_resp one cycle after rst.
  - Required: pmem_read=0 after the rst edge, and i_pmem_resp and d_pmem_resp remain 0.

Source files
------------

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one 256-bit physical-memory port between the I-cache
// and the D-cache. One line transaction at a time, round-robin on conflict,
// request fields latched at grant so memory sees a stable command.
module cache_arbiter (
    input  logic         clk,
    input  logic         rst,
    // I-cache side
    input  logic         i_pmem_read,
    input  logic [31:0]  i_pmem_address,
    output logic [255:0] i_pmem_rdata,
    output logic         i_pmem_resp,
    // D-cache side
    input  logic         d_pmem_read,
    input  logic         d_pmem_write,
    input  logic [31:0]  d_pmem_address,
    input  logic [255:0] d_pmem_wdata,
    output logic [255:0] d_pmem_rdata,
    output logic         d_pmem_resp,
    // Memory side
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           last_d_q, last_d_d;     // 1: D got the most recent grant
    logic           block_i_q, block_i_d;   // I just completed; skip it this IDLE cycle
    logic           block_d_q, block_d_d;   // D just completed; skip it this IDLE cycle
    logic [31:0]    addr_q, addr_d;
    logic [255:0]   wdata_q, wdata_d;
    logic           cmd_wr_q, cmd_wr_d;     // 1: write-back, 0: line read
    logic           elig_i, elig_d;
    logic           grant_i, grant_d;

    // Read data is shared; each cache only looks at it while its resp is high.
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // Arbitration, grant latching and response forwarding.
    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        block_i_d   = 1'b0;
        block_d_d   = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cmd_wr_d    = cmd_wr_q;
        pmem_read   = 1'b0;
        pmem_write  = 1'b0;
        i_pmem_resp = 1'b0;
        d_pmem_resp = 1'b0;
        grant_i     = 1'b0;
        grant_d     = 1'b0;
        elig_i      = i_pmem_read & ~block_i_q;
        elig_d      = (d_pmem_read | d_pmem_write) & ~block_d_q;

        case (state_q)
            IDLE: begin
                // On conflict the side that did not win last time goes first.
                if (elig_i && elig_d) begin
                    grant_d = ~last_d_q;
                    grant_i = last_d_q;
                end else begin
                    grant_i = elig_i;
                    grant_d = elig_d;
                end

                if (grant_i) begin
                    addr_d   = i_pmem_address;
                    cmd_wr_d = 1'b0;
                    last_d_d = 1'b0;
                    state_d  = SERVE_I;
                end else if (grant_d) begin
                    addr_d   = d_pmem_address;
                    wdata_d  = d_pmem_wdata;
                    // read+write together is illegal; write wins so dirty data is not lost
                    cmd_wr_d = d_pmem_write;
                    last_d_d = 1'b1;
                    state_d  = SERVE_D;
                end
            end

            SERVE_I: begin
                pmem_read   = ~cmd_wr_q;
                pmem_write  = cmd_wr_q;
                i_pmem_resp = pmem_resp;
                if (pmem_resp) begin
                    block_i_d = 1'b1;
                    state_d   = IDLE;
                end
            end

            SERVE_D: begin
                pmem_read   = ~cmd_wr_q;
                pmem_write  = cmd_wr_q;
                d_pmem_resp = pmem_resp;
                if (pmem_resp) begin
                    block_d_d = 1'b1;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched request registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            last_d_q  <= 1'b0;
            block_i_q <= 1'b0;
            block_d_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            cmd_wr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_d_q  <= last_d_d;
            block_i_q <= block_i_d;
            block_d_q <= block_d_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            cmd_wr_q  <= cmd_wr_d;
        end
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_cache_arbiter;

    logic         clk;
    logic         rst;
    logic         i_pmem_read;
    logic [31:0]  i_pmem_address;
    logic [255:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [31:0]  d_pmem_address;
    logic [255:0] d_pmem_wdata;
    logic [255:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    cache_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: who owns memory (0 none, 1 I, 2 D), what was latched,
    // who won last, and the cycle in which each side last completed.
    int           m_owner;
    int           m_last;
    int           m_rc_i;
    int           m_rc_d;
    logic [31:0]  m_addr;
    logic [255:0] m_wdata;
    logic         m_write;

    // Observation logs used by the directed scenarios.
    int           resp_log[$];
    int           rd_cycles;
    int           cmd_start_cyc;
    logic         prev_cmd;
    logic [255:0] last_i_rdata;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_last  = 1;
        m_rc_i  = -10;
        m_rc_d  = -10;
        m_addr  = '0;
        m_wdata = '0;
        m_write = 1'b0;
    endtask

    task automatic idle_inputs();
        i_pmem_read    = 1'b0;
        i_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        pmem_resp      = 1'b0;
        pmem_rdata     = '0;
    endtask

    // One clock cycle: compare outputs mid-cycle, advance the model, then cross the edge.
    task automatic cycle();
        logic ei, ed;
        int   win;
        @(negedge clk);
        chk("pmem_read",    256'(m_owner != 0 && !m_write), 256'(pmem_read));
        chk("pmem_write",   256'(pmem_write),   256'(m_owner != 0 && m_write));
        chk("pmem_address", 256'(pmem_address), 256'(m_addr));
        chk("pmem_wdata",   pmem_wdata,         m_wdata);
        chk("i_pmem_resp",  256'(i_pmem_resp),  256'(m_owner == 1 && pmem_resp));
        chk("d_pmem_resp",  256'(d_pmem_resp),  256'(m_owner == 2 && pmem_resp));
        chk("i_pmem_rdata", i_pmem_rdata,       pmem_rdata);
        chk("d_pmem_rdata", d_pmem_rdata,       pmem_rdata);

        if (i_pmem_resp) begin
            resp_log.push_back(1);
            last_i_rdata = i_pmem_rdata;
        end
        if (d_pmem_resp) resp_log.push_back(2);
        if (pmem_read) rd_cycles++;
        if ((pmem_read || pmem_write) && !prev_cmd) cmd_start_cyc = cyc;
        prev_cmd = pmem_read || pmem_write;

        if (rst) begin
            model_reset();
        end else if (m_owner != 0) begin
            if (pmem_resp) begin
                if (m_owner == 1) m_rc_i = cyc;
                else              m_rc_d = cyc;
                m_owner = 0;
            end
        end else begin
            ei  = i_pmem_read && (m_rc_i != cyc - 1);
            ed  = (d_pmem_read || d_pmem_write) && (m_rc_d != cyc - 1);
            win = 0;
            if (ei && ed)  win = (m_last == 1) ? 2 : 1;
            else if (ei)   win = 1;
            else if (ed)   win = 2;
            if (win == 1) begin
                m_addr  = i_pmem_address;
                m_write = 1'b0;
            end
            if (win == 2) begin
                m_addr  = d_pmem_address;
                m_wdata = d_pmem_wdata;
                m_write = d_pmem_write;
            end
            if (win != 0) begin
                m_owner = win;
                m_last  = win;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int          m;
        logic [31:0] tmp;

        rst = 1'b1;
        idle_inputs();
        model_reset();
        prev_cmd     = 1'b0;
        rd_cycles    = 0;
        cmd_start_cyc = -1;
        last_i_rdata = '0;
        @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;
        chk("reset_outputs", 256'({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}), 256'(4'b0000));
        chk("reset_address", 256'(pmem_address), 256'(32'h0));
        chk("reset_wdata",   pmem_wdata, 256'h0);

        // Lone I read, memory answers in the fifth command cycle.
        rd_cycles = 0;
        resp_log.delete();
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_0040;
        cycle();
        for (int k = 1; k <= 5; k++) begin
            chk("t1_addr", 256'(pmem_address), 256'(32'h40));
            if (k == 5) begin
                pmem_resp  = 1'b1;
                pmem_rdata = {32{8'hA5}};
            end
            cycle();
        end
        pmem_resp   = 1'b0;
        i_pmem_read = 1'b0;
        cycle();
        chk("t1_read_cycles", 256'(rd_cycles), 256'(5));
        chk("t1_resp_count",  256'(resp_log.size()), 256'(1));
        if (resp_log.size() > 0) chk("t1_resp_side", 256'(resp_log[0]), 256'(1));
        chk("t1_rdata", last_i_rdata, {32{8'hA5}});

        // Simultaneous I read and D write straight after reset: D first.
        do_reset();
        resp_log.delete();
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_0100;
        d_pmem_write   = 1'b1;
        d_pmem_address = 32'h0000_0200;
        d_pmem_wdata   = 256'h1234;
        cycle();
        chk("t2_d_cmd",   256'({pmem_read, pmem_write}), 256'(2'b01));
        chk("t2_d_addr",  256'(pmem_address), 256'(32'h200));
        chk("t2_d_wdata", pmem_wdata, 256'h1234);
        m = cyc;
        pmem_resp = 1'b1;
        cycle();
        pmem_resp    = 1'b0;
        d_pmem_write = 1'b0;
        cycle();
        chk("t2_i_cmd",  256'({pmem_read, pmem_write}), 256'(2'b10));
        chk("t2_i_addr", 256'(pmem_address), 256'(32'h100));
        pmem_resp = 1'b1;
        cycle();
        chk("t2_i_start", 256'(cmd_start_cyc), 256'(m + 2));
        i_pmem_read = 1'b0;
        pmem_resp   = 1'b0;
        cycle();
        chk("t2_resp_count", 256'(resp_log.size()), 256'(2));
        if (resp_log.size() == 2)
            chk("t2_order", 256'(resp_log[0] * 10 + resp_log[1]), 256'(21));

        // Sustained contention with instant memory: grants alternate D,I,D,I,D,I.
        do_reset();
        resp_log.delete();
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_0400;
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h0000_0800;
        pmem_resp      = 1'b1;
        repeat (12) cycle();
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
        pmem_resp   = 1'b0;
        cycle();
        chk("t3_count", 256'(resp_log.size()), 256'(6));
        for (int k = 0; k < 6 && k < resp_log.size(); k++)
            chk($sformatf("t3_grant%0d", k), 256'(resp_log[k]), 256'((k % 2 == 0) ? 2 : 1));

        // Blackout: I holds its request one cycle past resp -> no repeat read.
        do_reset();
        rd_cycles      = 0;
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_0540;
        cycle();
        cycle();
        pmem_resp  = 1'b1;
        pmem_rdata = {8{32'hDEAD_BEEF}};
        cycle();
        pmem_resp = 1'b0;
        cycle();
        i_pmem_read = 1'b0;
        repeat (3) cycle();
        chk("t4_single_read", 256'(rd_cycles), 256'(2));

        // Blackout: I re-requests continuously -> next command no earlier than M+3.
        i_pmem_read = 1'b1;
        cycle();
        cycle();
        m = cyc;
        pmem_resp = 1'b1;
        cycle();
        pmem_resp = 1'b0;
        repeat (3) cycle();
        chk("t4_regrant", 256'(cmd_start_cyc), 256'(m + 3));
        i_pmem_read = 1'b0;
        pmem_resp   = 1'b1;
        cycle();
        pmem_resp = 1'b0;
        cycle();

        // Requester changes its inputs mid-transaction: latched values hold.
        do_reset();
        d_pmem_read    = 1'b1;
        d_pmem_address = 32'h0000_0300;
        cycle();
        d_pmem_address = 32'hFFFF_FFE0;
        d_pmem_write   = 1'b1;
        d_pmem_wdata   = '1;
        for (int k = 0; k < 3; k++) begin
            chk("t5_addr", 256'(pmem_address), 256'(32'h300));
            chk("t5_cmd",  256'({pmem_read, pmem_write}), 256'(2'b10));
            if (k == 2) pmem_resp = 1'b1;
            cycle();
        end
        idle_inputs();
        cycle();

        // Reset during SERVE_I, late memory response afterwards.
        do_reset();
        resp_log.delete();
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_0660;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        chk("t6_cmd_after_rst", 256'({pmem_read, pmem_write}), 256'(2'b00));
        rst         = 1'b0;
        i_pmem_read = 1'b0;
        pmem_resp   = 1'b1;
        cycle();
        pmem_resp = 1'b0;
        cycle();
        chk("t6_no_resp", 256'(resp_log.size()), 256'(0));

        // Random traffic, including illegal read+write, stray resp and resets.
        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom_range(0, 99) == 0);
            i_pmem_read    = ($urandom_range(0, 9) < 7);
            tmp            = $urandom();
            i_pmem_address = tmp & 32'hFFFF_FFE0;
            d_pmem_read    = ($urandom_range(0, 9) < 6);
            d_pmem_write   = ($urandom_range(0, 9) < 3);
            tmp            = $urandom();
            d_pmem_address = tmp & 32'hFFFF_FFE0;
            for (int j = 0; j < 8; j++) begin
                d_pmem_wdata[j*32 +: 32] = $urandom();
                pmem_rdata[j*32 +: 32]   = $urandom();
            end
            pmem_resp = ($urandom_range(0, 3) == 0);
            cycle();
        end
        rst = 1'b0;
        idle_inputs();
        cycle();

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
